qadd_rr_scheduler: RTL

- Shares one Q-point sign-extending adder among N_REQ requesters, e.g. neuron membrane-update engines.
- Round-robin arbitration selects one request per cycle.
- Accepted operands pass through a 2-stage registered pipeline, and the sum leaves with its requester ID on a valid/ready result port.
- The block sits between the neuron-update units and the shared adder resource. One result is produced per cycle when the result port is not backpressured.

---
 rtl/qadd_pkg.sv | 20 ++
 rtl/qadd.sv | 18 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/qadd_rr_scheduler.sv | 96 +++++++++
 4 files changed

// File: rtl/qadd_pkg.sv
// Shared definitions for the Q-point adder scheduler: default widths, ID sizing
// and the result record carried on the result port.
package qadd_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_INP_WIDTH = 16;

    // Requester index width; a 2-requester block still needs one ID bit.
    function automatic int id_w(input int n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

    localparam int DEF_ID_W = id_w(DEF_N_REQ);

    typedef struct packed {
        logic [DEF_INP_WIDTH:0] sum;
        logic [DEF_ID_W-1:0]    id;
    } res_rec_t;

endpackage

// File: rtl/qadd.sv
// Q-point adder: sign-extends both operands to OUT_WIDTH and adds them exactly.
module qadd #(
    parameter int INP_WIDTH = 16,
    parameter int OUT_WIDTH = INP_WIDTH + 1
) (
    input  logic [INP_WIDTH-1:0] a,
    input  logic [INP_WIDTH-1:0] b,
    output logic [OUT_WIDTH-1:0] sum
);

    logic [OUT_WIDTH-1:0] a_ext;
    logic [OUT_WIDTH-1:0] b_ext;

    assign a_ext = {{(OUT_WIDTH-INP_WIDTH){a[INP_WIDTH-1]}}, a};
    assign b_ext = {{(OUT_WIDTH-INP_WIDTH){b[INP_WIDTH-1]}}, b};
    assign sum   = a_ext + b_ext;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid requester at or above rr_ptr (wrapping)
// wins; the grant is suppressed when en is low.
module rr_arbiter
    import qadd_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_valid
);

    logic [ID_W:0]   probe_sum;
    logic [ID_W-1:0] probe_idx;
    logic            found;

    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        probe_sum = '0;
        probe_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            probe_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (probe_sum >= (ID_W+1)'(N_REQ)) begin
                probe_sum = probe_sum - (ID_W+1)'(N_REQ);
            end
            probe_idx = probe_sum[ID_W-1:0];
            if (!found && req_valid[probe_idx]) begin
                found     = 1'b1;
                grant_idx = probe_idx;
            end
        end
        grant_valid = en && found;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/qadd_rr_scheduler.sv
// Shares one Q-point adder among N_REQ requesters: round-robin grant, operand
// register, result register, valid/ready result port with requester ID.
module qadd_rr_scheduler
    import qadd_pkg::*;
#(
    parameter  int N_REQ     = DEF_N_REQ,
    parameter  int INP_WIDTH = DEF_INP_WIDTH,
    localparam int OUT_WIDTH = INP_WIDTH + 1,
    localparam int ID_W      = id_w(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*INP_WIDTH-1:0] req_a,
    input  logic [N_REQ*INP_WIDTH-1:0] req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUT_WIDTH-1:0]       res_sum,
    output logic [ID_W-1:0]            res_id,
    output logic                       busy
);

    logic                 s1_v;
    logic [INP_WIDTH-1:0] s1_a;
    logic [INP_WIDTH-1:0] s1_b;
    logic [ID_W-1:0]      s1_id;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_idx;
    logic                 transfer;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 arb_en;
    logic [OUT_WIDTH-1:0] add_sum;

    assign s2_adv = !res_valid || res_ready;
    assign s1_adv = !s1_v || s2_adv;
    // Grants are masked while reset is held so nothing is offered mid-reset.
    assign arb_en = s1_adv && !rst;
    assign busy   = s1_v || res_valid;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arbiter (
        .req_valid  (req_valid),
        .rr_ptr     (rr_ptr),
        .en         (arb_en),
        .grant      (req_ready),
        .grant_idx  (grant_idx),
        .grant_valid(transfer)
    );

    qadd #(
        .INP_WIDTH(INP_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_qadd (
        .a  (s1_a),
        .b  (s1_b),
        .sum(add_sum)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            s1_v      <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
        end else begin
            if (transfer) begin
                rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                s1_v   <= 1'b1;
            end else if (s1_adv) begin
                s1_v   <= 1'b0;
            end
            if (s2_adv) begin
                res_valid <= s1_v;
                res_sum   <= add_sum;
                res_id    <= s1_id;
            end
        end
    end

    // NOTE: operand registers carry no reset; s1_v qualifies them, so their
    // contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (transfer) begin
            s1_a  <= req_a[int'(grant_idx)*INP_WIDTH +: INP_WIDTH];
            s1_b  <= req_b[int'(grant_idx)*INP_WIDTH +: INP_WIDTH];
            s1_id <= grant_idx;
        end
    end

endmodule
